// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: turns a manual/external step input or a free-run divider
// into a single-cycle clock enable for a core running on CLK_50.
// Also provides a halt gate and a wrapping count of issued enables.
module clk_step_ctrl #(
   parameter int unsigned DIVISOR         = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             CLK_50,
   input  logic             RESET,
   input  logic             STEP_IN,
   input  logic             SEL,
   input  logic             HALT,
   output logic             CLK_EN,
   output logic             MODE,
   output logic [CNT_W-1:0] STEP_CNT
);

   typedef enum logic {
      MODE_STEP = 1'b0,
      MODE_FREE = 1'b1
   } mode_e;

   localparam logic [31:0] DIV_LAST = 32'(DIVISOR - 1);
   localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);

   logic             step_s1_q, step_s1_d;
   logic             step_s2_q, step_s2_d;
   logic             sel_s1_q,  sel_s1_d;
   logic             sel_s2_q,  sel_s2_d;
   logic             filt_q,    filt_d;
   logic             filt_dly_q, filt_dly_d;
   logic [31:0]      db_cnt_q,  db_cnt_d;
   mode_e            mode_q,    mode_d;
   logic [31:0]      div_cnt_q, div_cnt_d;
   logic             clk_en_q,  clk_en_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic             step_edge;

   // All state registers; synchronous active-high reset clears everything.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         step_s1_q  <= 1'b0;
         step_s2_q  <= 1'b0;
         sel_s1_q   <= 1'b0;
         sel_s2_q   <= 1'b0;
         filt_q     <= 1'b0;
         filt_dly_q <= 1'b0;
         db_cnt_q   <= '0;
         mode_q     <= MODE_STEP;
         div_cnt_q  <= '0;
         clk_en_q   <= 1'b0;
         step_cnt_q <= '0;
      end else begin
         step_s1_q  <= step_s1_d;
         step_s2_q  <= step_s2_d;
         sel_s1_q   <= sel_s1_d;
         sel_s2_q   <= sel_s2_d;
         filt_q     <= filt_d;
         filt_dly_q <= filt_dly_d;
         db_cnt_q   <= db_cnt_d;
         mode_q     <= mode_d;
         div_cnt_q  <= div_cnt_d;
         clk_en_q   <= clk_en_d;
         step_cnt_q <= step_cnt_d;
      end
   end

   // Two-flop synchronisers and the step debouncer (runs in both modes).
   always_comb begin
      step_s1_d  = STEP_IN;
      step_s2_d  = step_s1_q;
      sel_s1_d   = SEL;
      sel_s2_d   = sel_s1_q;
      filt_d     = filt_q;
      db_cnt_d   = db_cnt_q;
      filt_dly_d = filt_q;
      if (step_s2_q == filt_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         filt_d   = step_s2_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 32'd1;
      end
   end

   // Mode FSM: mode switch, step-edge enable, free-run divider and halt gate.
   always_comb begin
      mode_d    = mode_q;
      div_cnt_d = div_cnt_q;
      clk_en_d  = 1'b0;
      step_edge = filt_q & ~filt_dly_q;
      if (mode_e'(sel_s2_q) != mode_q) begin
         // A mode switch swallows any coincident step edge.
         mode_d    = mode_e'(sel_s2_q);
         div_cnt_d = '0;
      end else begin
         case (mode_q)
            MODE_STEP: begin
               clk_en_d  = step_edge & ~HALT;
               div_cnt_d = '0;
            end
            MODE_FREE: begin
               if (!HALT) begin
                  if (div_cnt_q == DIV_LAST) begin
                     div_cnt_d = '0;
                     clk_en_d  = 1'b1;
                  end else begin
                     div_cnt_d = div_cnt_q + 32'd1;
                  end
               end
            end
         endcase
      end
   end

   // Wrapping count of issued enables, bumped the cycle after each pulse.
   always_comb begin
      step_cnt_d = step_cnt_q;
      if (clk_en_q) begin
         step_cnt_d = step_cnt_q + CNT_W'(1);
      end
   end

   assign CLK_EN   = clk_en_q;
   assign MODE     = (mode_q == MODE_FREE);
   assign STEP_CNT = step_cnt_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Self-checking bench for clk_step_ctrl (DIVISOR=4, DEBOUNCE_CYCLES=3, CNT_W=4).
// Directed scenarios followed by random stimulus, all checked every cycle
// against a behavioural model built from input histories and cycle counts.
module tb_clk_step_ctrl;

   localparam int unsigned DIV = 4;
   localparam int unsigned DB  = 3;
   localparam int unsigned CW  = 4;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic          step_in = 1'b0;
   logic          sel     = 1'b0;
   logic          halt    = 1'b0;
   logic          clk_en;
   logic          mode;
   logic [CW-1:0] step_cnt;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   int unsigned edge_no  = 0;
   int unsigned pulses   = 0;
   int unsigned last_pulse_edge = 0;
   bit          checks_on = 1'b0;

   // Reference model state
   bit          m_s1, m_s2, m_sel1, m_sel2;
   bit          m_filt, m_filt_prev, m_mode, m_en;
   int unsigned m_active, m_cnt;
   bit          win[$];

   clk_step_ctrl #(
      .DIVISOR         (DIV),
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (CW)
   ) dut (
      .CLK_50   (clk),
      .RESET    (rst),
      .STEP_IN  (step_in),
      .SEL      (sel),
      .HALT     (halt),
      .CLK_EN   (clk_en),
      .MODE     (mode),
      .STEP_CNT (step_cnt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Advance the model by one clock edge using the inputs present at that edge.
   // filt accepts level v once the last DB synchronised samples all equal v;
   // free-run pulses fall on every DIV-th unhalted cycle since entering the mode.
   function automatic void model_edge();
      bit step_edge, en_new, all_same;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_sel1 = 0; m_sel2 = 0;
         m_filt = 0; m_filt_prev = 0; m_mode = 0; m_en = 0;
         m_active = 0; m_cnt = 0;
         win.delete();
      end else begin
         step_edge = m_filt && !m_filt_prev;
         en_new    = 0;
         m_cnt     = (m_cnt + (m_en ? 1 : 0)) % (1 << CW);
         if (m_sel2 != m_mode) begin
            m_mode   = m_sel2;
            m_active = 0;
         end else if (!m_mode) begin
            en_new = step_edge && !halt;
         end else if (!halt) begin
            m_active = (m_active + 1) % DIV;
            en_new   = (m_active == 0);
         end
         m_en        = en_new;
         m_filt_prev = m_filt;
         win.push_back(m_s2);
         if (win.size() > DB) void'(win.pop_front());
         if (win.size() == DB) begin
            all_same = 1;
            foreach (win[i]) if (win[i] != win[0]) all_same = 0;
            if (all_same && win[0] != m_filt) m_filt = win[0];
         end
         m_s2   = m_s1;
         m_s1   = step_in;
         m_sel2 = m_sel1;
         m_sel1 = sel;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   // One clock: update the model at the edge, compare outputs at the falling edge.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      edge_no++;
      @(negedge clk);
      if (checks_on) begin
         chk($sformatf("clk_en@%0d", edge_no), {31'd0, clk_en}, {31'd0, m_en});
         chk($sformatf("mode@%0d", edge_no), {31'd0, mode}, {31'd0, m_mode});
         chk($sformatf("step_cnt@%0d", edge_no), {28'd0, step_cnt}, CW'(m_cnt));
      end
      if (clk_en === 1'b1) begin
         pulses++;
         last_pulse_edge = edge_no;
      end
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset(input int unsigned n);
      rst = 1'b1;
      run(n);
      rst = 1'b0;
   endtask

   // Wait for the next pulse, bounded; reports whether one was seen.
   task automatic wait_pulse(input int unsigned limit, output bit seen);
      int unsigned p0;
      p0   = pulses;
      seen = 0;
      for (int unsigned i = 0; i < limit && !seen; i++) begin
         cyc();
         if (pulses != p0) seen = 1;
      end
   endtask

   initial begin
      int unsigned base, p_edge;
      bit seen;

      // 1: reset, then idle
      rst = 1'b1;
      cyc();
      checks_on = 1'b1;
      cyc();
      rst = 1'b0;
      pulses = 0;
      run(20);
      chk("idle_pulses", pulses, 0);
      chk("idle_mode", {31'd0, mode}, 0);
      chk("idle_cnt", {28'd0, step_cnt}, 0);

      // 2: single held step gives exactly one pulse, 5 edges after sampling
      base = edge_no;
      step_in = 1'b1;
      pulses = 0;
      run(20);
      chk("step_pulses", pulses, 1);
      chk("step_latency", last_pulse_edge, base + 1 + 2 + DB);
      chk("step_cnt1", {28'd0, step_cnt}, 1);
      step_in = 1'b0;
      run(10);
      chk("step_release_pulses", pulses, 1);

      // 3: bounce shorter than debounce window
      do_reset(2);
      pulses = 0;
      step_in = 1'b1; run(2);
      step_in = 1'b0; run(3);
      step_in = 1'b1; run(2);
      step_in = 1'b0; run(10);
      chk("bounce_pulses", pulses, 0);
      chk("bounce_cnt", {28'd0, step_cnt}, 0);

      // 4: free-run entry with slow step toggling
      do_reset(2);
      base = edge_no;
      sel = 1'b1;
      pulses = 0;
      run(2);
      chk("mode_not_yet", {31'd0, mode}, 0);
      run(1);
      chk("mode_entered", {31'd0, mode}, 1);
      for (int unsigned i = 0; i < 3; i++) begin
         step_in = ~step_in;
         run(5);
      end
      step_in = 1'b0;
      chk("free_pulses", pulses, 3);
      chk("free_last", last_pulse_edge, base + 1 + 2 + 3 * DIV);

      // 5: halt stretches the period by the halted cycles
      wait_pulse(10, seen);
      chk("halt_sync_seen", {31'd0, seen}, 1);
      p_edge = last_pulse_edge;
      halt = 1'b1; run(5);
      halt = 1'b0;
      wait_pulse(20, seen);
      chk("halt_resume_seen", {31'd0, seen}, 1);
      chk("halt_gap", last_pulse_edge - p_edge, DIV + 5);
      sel = 1'b0;
      run(6);
      pulses = 0;
      halt = 1'b1;
      step_in = 1'b1;
      run(10);
      chk("step_halt_dropped", pulses, 0);
      halt = 1'b0;
      run(4);
      chk("step_not_queued", pulses, 0);
      step_in = 1'b0;
      run(8);

      // 6: wrap after 16 pulses, reset mid-period, restart latency
      sel = 1'b1;
      do_reset(2);
      pulses = 0;
      for (int unsigned i = 0; i < 120 && pulses < 16; i++) cyc();
      chk("wrap_pulses", pulses, 16);
      run(1);
      chk("wrap_cnt", {28'd0, step_cnt}, 0);
      run(1);
      rst = 1'b1;
      pulses = 0;
      run(2);
      chk("rst_no_pulse", pulses, 0);
      chk("rst_clk_en", {31'd0, clk_en}, 0);
      chk("rst_mode", {31'd0, mode}, 0);
      chk("rst_cnt", {28'd0, step_cnt}, 0);
      base = edge_no;
      rst = 1'b0;
      wait_pulse(20, seen);
      chk("restart_seen", {31'd0, seen}, 1);
      chk("restart_latency", last_pulse_edge, base + 1 + 2 + DIV);

      // Random stimulus against the model
      for (int unsigned i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) step_in = ~step_in;
         halt = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 149) == 0) sel = ~sel;
         rst = ($urandom_range(0, 399) == 0);
         cyc();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
